// File: rtl/bru_redirect_if.sv
// Branch-unit / redirect / predictor-update bundle between EX, fetch and the predictor.
// Every valid/ready pair transfers on a rising clk edge where both are high; the valid side holds its payload stable until then.
`timescale 1ns/1ps
interface bru_redirect_if #(
  parameter int PC_W = 32
);
  logic            bru_valid;
  logic [PC_W-1:0] bru_pc;
  logic [PC_W-1:0] bru_true_pc;
  logic [PC_W-1:0] bru_pred_pc;
  logic            bru_taken;
  logic [2:0]      bru_type;
  logic            bru_likely_flush;
  logic            ds_issued;
  logic            exc_flush;
  logic            bru_stall;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            redirect_ready;
  logic            flush_front;
  logic            flush_ds;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic [PC_W-1:0] upd_target;
  logic            upd_taken;
  logic [2:0]      upd_type;
  logic            upd_ready;

  // master: the pipeline/fetch/predictor side; slave: the redirect controller
  modport master (
    output bru_valid, bru_pc, bru_true_pc, bru_pred_pc, bru_taken, bru_type,
           bru_likely_flush, ds_issued, exc_flush, redirect_ready, upd_ready,
    input  bru_stall, redirect_valid, redirect_pc, flush_front, flush_ds,
           upd_valid, upd_pc, upd_target, upd_taken, upd_type
  );

  modport slave (
    input  bru_valid, bru_pc, bru_true_pc, bru_pred_pc, bru_taken, bru_type,
           bru_likely_flush, ds_issued, exc_flush, redirect_ready, upd_ready,
    output bru_stall, redirect_valid, redirect_pc, flush_front, flush_ds,
           upd_valid, upd_pc, upd_target, upd_taken, upd_type
  );
endinterface

// File: rtl/bru_redirect_ctrl.sv
// Mispredict recovery sequencer (delay slot wait / annul, held redirect to fetch)
// plus a small FIFO of predictor-update records for resolved control transfers.
`timescale 1ns/1ps
module bru_redirect_ctrl #(
  parameter int PC_W      = 32,
  parameter int UPD_DEPTH = 4
) (
  input  logic           clk,
  input  logic           resetn,
  bru_redirect_if.slave  bus,
  output logic [1:0]     state_dbg
);

  localparam int PTR_W = $clog2(UPD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 * PC_W + 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_DS  = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  state_e           state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [ENT_W-1:0] upd_mem [UPD_DEPTH];

  logic fifo_full;
  logic stall;
  logic accept;
  logic mispredict;
  logic upd_push;
  logic upd_pop;

  assign fifo_full  = (count == CNT_W'(UPD_DEPTH));
  // Stall is built from registers only so the branch unit never sees a loop through bru_valid
  assign stall      = (state != IDLE) | fifo_full;
  assign accept     = bus.bru_valid & ~stall & ~bus.exc_flush;
  assign mispredict = (bus.bru_true_pc != bus.bru_pred_pc);
  assign upd_push   = accept & (bus.bru_type != 3'd0);
  assign upd_pop    = (count != '0) & bus.upd_ready;

  assign bus.bru_stall = stall;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state              <= IDLE;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.flush_front    <= 1'b0;
      bus.flush_ds       <= 1'b0;
    end else begin
      bus.flush_front <= 1'b0;
      bus.flush_ds    <= 1'b0;
      if (bus.exc_flush) begin
        // Exception wins over everything: drop any pending target silently
        state              <= IDLE;
        bus.redirect_valid <= 1'b0;
        bus.redirect_pc    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (bus.bru_likely_flush) begin
                bus.flush_ds       <= 1'b1;
                bus.redirect_pc    <= bus.bru_true_pc;
                bus.redirect_valid <= 1'b1;
                state              <= REDIRECT;
              end else if (mispredict) begin
                bus.redirect_pc <= bus.bru_true_pc;
                if (bus.ds_issued) begin
                  bus.redirect_valid <= 1'b1;
                  state              <= REDIRECT;
                end else begin
                  state <= WAIT_DS;
                end
              end
            end
          end
          WAIT_DS: begin
            if (bus.ds_issued) begin
              bus.redirect_valid <= 1'b1;
              state              <= REDIRECT;
            end
          end
          REDIRECT: begin
            if (bus.redirect_ready) begin
              bus.redirect_valid <= 1'b0;
              bus.flush_front    <= 1'b1;
              state              <= IDLE;
            end
          end
          default: begin
            bus.redirect_valid <= 1'b0;
            state              <= IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (upd_push) wr_ptr <= wr_ptr + 1'b1;
      if (upd_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({upd_push, upd_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observable while count says they are valid
  always_ff @(posedge clk) begin
    if (upd_push) begin
      upd_mem[wr_ptr] <= {bus.bru_pc, bus.bru_true_pc, bus.bru_taken, bus.bru_type};
    end
  end

  assign bus.upd_valid = (count != '0);
  assign {bus.upd_pc, bus.upd_target, bus.upd_taken, bus.upd_type} = upd_mem[rd_ptr];

endmodule

// File: tb/tb_bru_redirect_ctrl.sv
// Self-checking bench for bru_redirect_ctrl: directed scenarios plus a randomized FIFO run,
// with scoreboard queues for predictor updates and accepted redirects.
`timescale 1ns/1ps
module tb_bru_redirect_ctrl;
  localparam int PC_W      = 32;
  localparam int UPD_DEPTH = 4;
  localparam int ENT_W     = 2 * PC_W + 4;

  logic             clk = 1'b0;
  logic             resetn;
  logic [1:0]       state_dbg;
  int               errors = 0;
  int               checks = 0;
  logic [ENT_W-1:0] exp_q[$];
  logic [PC_W-1:0]  rq[$];
  logic [ENT_W-1:0] mon_ent;
  logic [PC_W-1:0]  mon_pc;

  always #5 clk = ~clk;

  bru_redirect_if #(.PC_W(PC_W)) bus ();

  bru_redirect_ctrl #(.PC_W(PC_W), .UPD_DEPTH(UPD_DEPTH)) u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Scoreboard: inputs are driven at negedge, so negedge+1 sees this cycle's handshakes
  always @(negedge clk) begin
    #1;
    if (resetn === 1'b1) begin
      if (bus.upd_valid === 1'b1 && bus.upd_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL upd_pop: got %h required no entry", {bus.upd_pc, bus.upd_target, bus.upd_taken, bus.upd_type});
        end else begin
          mon_ent = exp_q.pop_front();
          if ({bus.upd_pc, bus.upd_target, bus.upd_taken, bus.upd_type} !== mon_ent) begin
            errors++;
            $display("FAIL upd_pop: got %h required %h", {bus.upd_pc, bus.upd_target, bus.upd_taken, bus.upd_type}, mon_ent);
          end
        end
      end
      if (bus.redirect_valid === 1'b1 && bus.redirect_ready === 1'b1) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL redirect_hs: got %h required no redirect", bus.redirect_pc);
        end else begin
          mon_pc = rq.pop_front();
          if (bus.redirect_pc !== mon_pc) begin
            errors++;
            $display("FAIL redirect_hs: got %h required %h", bus.redirect_pc, mon_pc);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_br();
    bus.bru_valid        = 1'b0;
    bus.ds_issued        = 1'b0;
    bus.bru_likely_flush = 1'b0;
    bus.exc_flush        = 1'b0;
  endtask

  task automatic idle_inputs();
    clear_br();
    bus.bru_pc         = '0;
    bus.bru_true_pc    = '0;
    bus.bru_pred_pc    = '0;
    bus.bru_taken      = 1'b0;
    bus.bru_type       = 3'd0;
    bus.redirect_ready = 1'b1;
    bus.upd_ready      = 1'b1;
  endtask

  task automatic drive_br(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tpc,
                          input logic [PC_W-1:0] ppc, input logic taken,
                          input logic [2:0] typ, input logic likely, input logic ds);
    bus.bru_valid        = 1'b1;
    bus.bru_pc           = pc;
    bus.bru_true_pc      = tpc;
    bus.bru_pred_pc      = ppc;
    bus.bru_taken        = taken;
    bus.bru_type         = typ;
    bus.bru_likely_flush = likely;
    bus.ds_issued        = ds;
  endtask

  task automatic test_reset();
    checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_rv: got %b required 0", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== '0) begin errors++; $display("FAIL rst_rpc: got %h required 0", bus.redirect_pc); end
    checks++; if (bus.flush_front !== 1'b0) begin errors++; $display("FAIL rst_ff: got %b required 0", bus.flush_front); end
    checks++; if (bus.flush_ds !== 1'b0) begin errors++; $display("FAIL rst_fds: got %b required 0", bus.flush_ds); end
    checks++; if (bus.upd_valid !== 1'b0) begin errors++; $display("FAIL rst_uv: got %b required 0", bus.upd_valid); end
    checks++; if (bus.bru_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b required 0", bus.bru_stall); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d required 0", state_dbg); end
  endtask

  task automatic test_correct_predict();
    drive_br(32'h1000, 32'h1008, 32'h1008, 1'b0, 3'd1, 1'b0, 1'b0);
    exp_q.push_back({32'h1000, 32'h1008, 1'b0, 3'd1});
    tick();
    clear_br();
    checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL cp_rv: got %b required 0", bus.redirect_valid); end
    checks++; if (bus.bru_stall !== 1'b0) begin errors++; $display("FAIL cp_stall: got %b required 0", bus.bru_stall); end
    checks++; if (bus.upd_valid !== 1'b1) begin errors++; $display("FAIL cp_uv: got %b required 1", bus.upd_valid); end
    checks++; if (bus.upd_pc !== 32'h1000) begin errors++; $display("FAIL cp_upc: got %h required 00001000", bus.upd_pc); end
    checks++; if (bus.upd_taken !== 1'b0) begin errors++; $display("FAIL cp_utk: got %b required 0", bus.upd_taken); end
    tick();
    checks++; if (bus.upd_valid !== 1'b0) begin errors++; $display("FAIL cp_drain: got %b required 0", bus.upd_valid); end
  endtask

  task automatic test_mispredict_ds();
    drive_br(32'h2000, 32'hBFC0_0100, 32'h2008, 1'b1, 3'd1, 1'b0, 1'b1);
    exp_q.push_back({32'h2000, 32'hBFC0_0100, 1'b1, 3'd1});
    rq.push_back(32'hBFC0_0100);
    tick();
    clear_br();
    checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL mp_rv: got %b required 1", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 32'hBFC0_0100) begin errors++; $display("FAIL mp_rpc: got %h required bfc00100", bus.redirect_pc); end
    checks++; if (bus.bru_stall !== 1'b1) begin errors++; $display("FAIL mp_stall1: got %b required 1", bus.bru_stall); end
    checks++; if (bus.flush_front !== 1'b0) begin errors++; $display("FAIL mp_ff1: got %b required 0", bus.flush_front); end
    tick();
    checks++; if (bus.flush_front !== 1'b1) begin errors++; $display("FAIL mp_ff2: got %b required 1", bus.flush_front); end
    checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL mp_rv2: got %b required 0", bus.redirect_valid); end
    checks++; if (bus.bru_stall !== 1'b0) begin errors++; $display("FAIL mp_stall2: got %b required 0", bus.bru_stall); end
    tick();
    checks++; if (bus.flush_front !== 1'b0) begin errors++; $display("FAIL mp_ff3: got %b required 0", bus.flush_front); end
  endtask

  task automatic test_wait_ds();
    drive_br(32'h4000, 32'h4100, 32'h4008, 1'b1, 3'd2, 1'b0, 1'b0);
    exp_q.push_back({32'h4000, 32'h4100, 1'b1, 3'd2});
    rq.push_back(32'h4100);
    tick();
    clear_br();
    for (int i = 0; i < 3; i++) begin
      checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL wd_state%0d: got %0d required 1", i, state_dbg); end
      checks++; if (bus.bru_stall !== 1'b1) begin errors++; $display("FAIL wd_stall%0d: got %b required 1", i, bus.bru_stall); end
      checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL wd_rv%0d: got %b required 0", i, bus.redirect_valid); end
      bus.ds_issued = (i == 2);
      tick();
    end
    bus.ds_issued = 1'b0;
    checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL wd_rv: got %b required 1", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 32'h4100) begin errors++; $display("FAIL wd_rpc: got %h required 00004100", bus.redirect_pc); end
    checks++; if (bus.flush_ds !== 1'b0) begin errors++; $display("FAIL wd_fds: got %b required 0", bus.flush_ds); end
    tick();
    checks++; if (bus.flush_front !== 1'b1) begin errors++; $display("FAIL wd_ff: got %b required 1", bus.flush_front); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL wd_idle: got %0d required 0", state_dbg); end
    tick();
  endtask

  task automatic test_likely();
    bus.redirect_ready = 1'b0;
    drive_br(32'h3004, 32'h300C, 32'h300C, 1'b0, 3'd1, 1'b1, 1'b0);
    exp_q.push_back({32'h3004, 32'h300C, 1'b0, 3'd1});
    rq.push_back(32'h300C);
    tick();
    clear_br();
    checks++; if (bus.flush_ds !== 1'b1) begin errors++; $display("FAIL lk_fds: got %b required 1", bus.flush_ds); end
    checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL lk_rv: got %b required 1", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 32'h300C) begin errors++; $display("FAIL lk_rpc: got %h required 0000300c", bus.redirect_pc); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL lk_hold_rv%0d: got %b required 1", i, bus.redirect_valid); end
      checks++; if (bus.redirect_pc !== 32'h300C) begin errors++; $display("FAIL lk_hold_rpc%0d: got %h required 0000300c", i, bus.redirect_pc); end
      checks++; if (bus.flush_ds !== 1'b0) begin errors++; $display("FAIL lk_hold_fds%0d: got %b required 0", i, bus.flush_ds); end
      checks++; if (bus.flush_front !== 1'b0) begin errors++; $display("FAIL lk_hold_ff%0d: got %b required 0", i, bus.flush_front); end
    end
    bus.redirect_ready = 1'b1;
    tick();
    checks++; if (bus.flush_front !== 1'b1) begin errors++; $display("FAIL lk_ff: got %b required 1", bus.flush_front); end
    tick();
  endtask

  task automatic test_fifo_full();
    logic [PC_W-1:0] pc;
    bus.upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc = 32'h5000 + PC_W'(i * 16);
      checks++; if (bus.bru_stall !== 1'b0) begin errors++; $display("FAIL ff_pre_stall%0d: got %b required 0", i, bus.bru_stall); end
      drive_br(pc, pc + 32'h100, pc + 32'h100, 1'b1, 3'd3, 1'b0, 1'b0);
      exp_q.push_back({pc, pc + 32'h100, 1'b1, 3'd3});
      tick();
    end
    drive_br(32'h5040, 32'h5140, 32'h5140, 1'b1, 3'd3, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.bru_stall !== 1'b1) begin errors++; $display("FAIL ff_full_stall%0d: got %b required 1", i, bus.bru_stall); end
      tick();
    end
    bus.upd_ready = 1'b1;
    tick();
    bus.upd_ready = 1'b0;
    checks++; if (bus.bru_stall !== 1'b0) begin errors++; $display("FAIL ff_pop_stall: got %b required 0", bus.bru_stall); end
    exp_q.push_back({32'h5040, 32'h5140, 1'b1, 3'd3});
    tick();
    clear_br();
    checks++; if (bus.bru_stall !== 1'b1) begin errors++; $display("FAIL ff_refill_stall: got %b required 1", bus.bru_stall); end
    bus.upd_ready = 1'b1;
    repeat (5) tick();
    checks++; if (bus.upd_valid !== 1'b0) begin errors++; $display("FAIL ff_drain: got %b required 0", bus.upd_valid); end
  endtask

  task automatic test_exc_flush();
    drive_br(32'h7000, 32'h7200, 32'h7008, 1'b1, 3'd1, 1'b0, 1'b0);
    exp_q.push_back({32'h7000, 32'h7200, 1'b1, 3'd1});
    tick();
    clear_br();
    checks++; if (state_dbg !== 2'd1) begin errors++; $display("FAIL ex_wait: got %0d required 1", state_dbg); end
    bus.exc_flush = 1'b1;
    tick();
    bus.exc_flush = 1'b0;
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL ex_idle: got %0d required 0", state_dbg); end
    checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL ex_rv: got %b required 0", bus.redirect_valid); end
    checks++; if (bus.flush_front !== 1'b0) begin errors++; $display("FAIL ex_ff: got %b required 0", bus.flush_front); end
    checks++; if (bus.bru_stall !== 1'b0) begin errors++; $display("FAIL ex_stall: got %b required 0", bus.bru_stall); end
    bus.ds_issued = 1'b1;
    tick();
    bus.ds_issued = 1'b0;
    checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL ex_late_ds: got %b required 0", bus.redirect_valid); end
    drive_br(32'h7400, 32'h7408, 32'h7500, 1'b0, 3'd1, 1'b1, 1'b1);
    bus.exc_flush = 1'b1;
    tick();
    clear_br();
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL exv_idle: got %0d required 0", state_dbg); end
    checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL exv_rv: got %b required 0", bus.redirect_valid); end
    checks++; if (bus.flush_ds !== 1'b0) begin errors++; $display("FAIL exv_fds: got %b required 0", bus.flush_ds); end
    checks++; if (bus.upd_valid !== 1'b0) begin errors++; $display("FAIL exv_push: got %b required 0", bus.upd_valid); end
    tick();
  endtask

  task automatic test_async_reset();
    bus.upd_ready      = 1'b0;
    bus.redirect_ready = 1'b0;
    drive_br(32'h6000, 32'h6100, 32'h6008, 1'b1, 3'd4, 1'b0, 1'b1);
    tick();
    clear_br();
    checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_rv: got %b required 1", bus.redirect_valid); end
    checks++; if (bus.upd_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_uv: got %b required 1", bus.upd_valid); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL ar_rv: got %b required 0", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== '0) begin errors++; $display("FAIL ar_rpc: got %h required 0", bus.redirect_pc); end
    checks++; if (bus.upd_valid !== 1'b0) begin errors++; $display("FAIL ar_uv: got %b required 0", bus.upd_valid); end
    checks++; if (bus.bru_stall !== 1'b0) begin errors++; $display("FAIL ar_stall: got %b required 0", bus.bru_stall); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL ar_state: got %0d required 0", state_dbg); end
    tick();
    resetn             = 1'b1;
    bus.upd_ready      = 1'b1;
    bus.redirect_ready = 1'b1;
    tick();
    checks++; if (bus.upd_valid !== 1'b0) begin errors++; $display("FAIL ar_post_uv: got %b required 0", bus.upd_valid); end
  endtask

  task automatic test_back_to_back();
    int   cnt;
    logic stall_exp;
    logic prev_stall;
    logic push;
    logic pop;
    logic [PC_W-1:0] pc;
    cnt        = 0;
    prev_stall = 1'b0;
    for (int i = 0; i < 40; i++) begin
      stall_exp = (cnt == UPD_DEPTH);
      checks++; if (bus.bru_stall !== stall_exp) begin errors++; $display("FAIL bb_stall%0d: got %b required %b", i, bus.bru_stall, stall_exp); end
      checks++; if (bus.upd_valid !== (cnt != 0)) begin errors++; $display("FAIL bb_uv%0d: got %b required %b", i, bus.upd_valid, (cnt != 0)); end
      if (!(bus.bru_valid && prev_stall)) begin
        pc = 32'h8000 + PC_W'(i * 4);
        bus.bru_valid   = ($urandom_range(0, 3) != 0);
        bus.bru_pc      = pc;
        bus.bru_true_pc = pc + PC_W'($urandom_range(1, 255) * 4);
        bus.bru_pred_pc = bus.bru_true_pc;
        bus.bru_taken   = 1'($urandom_range(0, 1));
        bus.bru_type    = 3'($urandom_range(0, 4));
      end
      bus.upd_ready = ($urandom_range(0, 2) == 0);
      push = bus.bru_valid && !stall_exp && (bus.bru_type != 3'd0);
      pop  = (cnt != 0) && bus.upd_ready;
      if (push) exp_q.push_back({bus.bru_pc, bus.bru_true_pc, bus.bru_taken, bus.bru_type});
      cnt        = cnt + int'(push) - int'(pop);
      prev_stall = stall_exp;
      tick();
    end
    clear_br();
    bus.upd_ready = 1'b1;
    repeat (6) tick();
    checks++; if (bus.upd_valid !== 1'b0) begin errors++; $display("FAIL bb_drain: got %b required 0", bus.upd_valid); end
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b0;
    tick();
    tick();
    test_reset();
    resetn = 1'b1;
    tick();
    test_correct_predict();
    test_mispredict_ds();
    test_wait_ds();
    test_likely();
    test_fifo_full();
    test_exc_flush();
    test_async_reset();
    test_back_to_back();
    tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_upd_left: got %0d required 0", exp_q.size()); end
    checks++; if (rq.size() != 0) begin errors++; $display("FAIL sb_redirect_left: got %0d required 0", rq.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
